// File: rtl/ram_pkg.sv
// ram_pkg -- shared definitions for the memory blocks of this slice.
//
// Holds the project-wide data word width so that every block sizing its
// data path from it stays in step. Nothing block-local (array types,
// state encodings) belongs here; each block keeps its storage private.
package ram_pkg;

    // Project-wide data word width in bits.
    localparam int DATA_WIDTH = 8;

endpackage : ram_pkg

// File: rtl/ram.sv
// ram -- single-port register-file RAM, clocked write, combinational read.
//
// Parameters
//   ADR_W   address width; depth is 2**ADR_W words
//   DATA_W  word width, defaults to the project-wide DATA_WIDTH
//
// Ports
//   clk    in   1       clock; all state changes on the rising edge
//   rst_n  in   1       synchronous active-low reset; clears every word
//   we     in   1       write enable, active-high
//   adr    in   ADR_W   word address, shared by read and write
//   din    in   DATA_W  write data
//   dout   out  DATA_W  read data, always mem[adr] with no latency
//
// The read is a plain continuous assignment, so dout follows adr within the
// same timestep and shows freshly written data right after the write edge.
// Because the read is asynchronous this maps to distributed/LUT storage or
// flops rather than a block RAM.
module ram
    import ram_pkg::*;
#(
    parameter int ADR_W  = 4,
    parameter int DATA_W = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADR_W-1:0]  adr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];

    // Reset wins over a write in the same cycle. An X/Z on rst_n makes the
    // reset condition non-true, so the else branch runs and writes proceed
    // as if reset were deasserted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[adr] <= din;
        end
    end

    assign dout = mem_reg[adr];

endmodule : ram

// File: tb/tb_ram.sv
// tb_ram -- randomized, scoreboard-checked bench for ram.
//
// The stimulus process drives the inputs, updates an array model of the
// memory, and pushes the expected dout into a queue once the inputs have
// settled. A separate monitor pops each entry and compares it with dout.
module tb_ram;

    localparam int ADR_W  = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 1 << ADR_W;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;

    ram #(
        .ADR_W  (ADR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .adr   (adr),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: word values plus a flag marking words whose content
    // is defined (written or reset at least once).
    logic [DATA_W-1:0] ref_mem   [DEPTH];
    bit                ref_known [DEPTH];

    // Scoreboard queues, kept in lockstep.
    logic [ADR_W-1:0]  exp_adr_q  [$];
    logic [DATA_W-1:0] exp_data_q [$];
    string             exp_name_q [$];

    int vectors     = 0;
    int miscompares = 0;

    // Queue an expectation for the current adr, if its content is defined.
    task automatic expect_now(input string name);
        if (ref_known[adr]) begin
            exp_adr_q.push_back(adr);
            exp_data_q.push_back(ref_mem[adr]);
            exp_name_q.push_back(name);
        end
    endtask

    // Combinational read: change adr away from any edge, let it settle,
    // then expect the model value without any clock edge in between.
    task automatic do_read(input logic [ADR_W-1:0] a, input string name);
        adr = a;
        #1;
        expect_now(name);
        #1;
    endtask

    // One write cycle. we stays high afterwards so consecutive calls give
    // back-to-back writes; do_idle drops it.
    task automatic do_write(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input string name);
        @(negedge clk);
        we  = 1'b1;
        adr = a;
        din = d;
        #1;
        expect_now({name, "_old"});
        @(posedge clk);
        if (rst_n !== 1'b0) begin
            ref_mem[a]   = d;
            ref_known[a] = 1'b1;
        end
        #1;
        expect_now({name, "_new"});
    endtask

    // Clock edges with we=0 and garbage on din; the addressed word must hold.
    task automatic do_idle(input logic [ADR_W-1:0] a, input int n, input string name);
        @(negedge clk);
        we  = 1'b0;
        adr = a;
        din = 8'hFF;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            expect_now(name);
        end
    endtask

    // One reset edge with a competing write request that must be discarded.
    task automatic do_reset(input logic [DATA_W-1:0] d);
        @(negedge clk);
        rst_n = 1'b0;
        we    = 1'b1;
        din   = d;
        @(posedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b1;
        end
        #1;
    endtask

    // Monitor: compares dout against each queued expectation.
    initial begin
        logic [ADR_W-1:0]  a;
        logic [DATA_W-1:0] e;
        string             n;
        forever begin
            wait (exp_data_q.size() > 0);
            a = exp_adr_q.pop_front();
            e = exp_data_q.pop_front();
            n = exp_name_q.pop_front();
            vectors++;
            if (dout !== e || adr !== a) begin
                miscompares++;
                $display("FAIL %s adr=%0d dout=%h expected=%h", n, a, dout, e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i]   = '0;
            ref_known[i] = 1'b0;
        end
        rst_n = 1'b1;
        we    = 1'b0;
        adr   = '0;
        din   = '0;

        // Reset state: every word reads zero while reset is still held.
        do_reset(8'h00);
        for (int i = 0; i < DEPTH; i++) do_read(i[ADR_W-1:0], "reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;

        // Single write then read back with no further edge.
        do_write(4'd5, 8'h55, "wr5");
        @(negedge clk);
        we = 1'b0;
        do_read(4'd5, "rd5_noedge");

        // Fill with A0+i back to back, then sweep combinationally.
        for (int i = 0; i < DEPTH; i++)
            do_write(i[ADR_W-1:0], 8'hA0 + i[DATA_W-1:0], "fill");
        @(negedge clk);
        we = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_read(i[ADR_W-1:0], "sweep");

        // Independence of neighbouring words.
        do_write(4'd3, 8'h11, "wr3");
        do_write(4'd4, 8'h22, "wr4");
        @(negedge clk);
        we = 1'b0;
        do_read(4'd3, "indep3");
        do_read(4'd4, "indep4");

        // No write with we=0.
        do_idle(4'd3, 3, "hold3");

        // Back-to-back writes to one address: last one wins.
        do_write(4'd9, 8'h01, "b2b");
        do_write(4'd9, 8'h02, "b2b");
        do_write(4'd9, 8'h03, "b2b");
        do_idle(4'd9, 1, "b2b_last");

        // Random mix of writes, idles and combinational reads.
        for (int t = 0; t < 300; t++) begin
            logic [ADR_W-1:0]  ra;
            logic [DATA_W-1:0] rd;
            ra = ADR_W'($urandom_range(DEPTH - 1, 0));
            rd = DATA_W'($urandom);
            case ($urandom_range(2, 0))
                0: do_write(ra, rd, "rnd_wr");
                1: do_idle(ra, 1, "rnd_idle");
                default: begin
                    @(negedge clk);
                    we = 1'b0;
                    do_read(ra, "rnd_rd");
                    do_read(ADR_W'($urandom_range(DEPTH - 1, 0)), "rnd_rd2");
                end
            endcase
        end

        // Reset with a concurrent write of 77: everything reads zero.
        do_reset(8'h77);
        for (int i = 0; i < DEPTH; i++) do_read(i[ADR_W-1:0], "reset_clear");

        // Release, top address reads zero, then accepts a write.
        @(negedge clk);
        rst_n = 1'b1;
        we    = 1'b0;
        do_read(4'd15, "top_before");
        do_write(4'd15, 8'h3C, "top_wr");
        @(negedge clk);
        we = 1'b0;
        do_read(4'd15, "top_after");
        do_read(4'd14, "top_neighbour");

        // Drain the scoreboard within a bounded time.
        for (int w = 0; w < 100 && exp_data_q.size() > 0; w++) #1;
        if (exp_data_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_data_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram
